// File: rtl/lsu_pkg.sv
// Shared types and encodings for the memory-stage load/store unit.
package lsu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables/replicated data, load extraction
// with sign/zero extension, and size/alignment fault detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_out,
  output logic [31:0] load_data,
  output logic        fault
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Shift the addressed lane down to bit 0 before extension.
  assign byte_shift = rdata >> {addr, 3'b000};
  assign half_shift = rdata >> {addr[1], 4'b0000};
  assign rd_byte    = byte_shift[7:0];
  assign rd_half    = half_shift[15:0];

  always_comb begin
    byte_en   = 4'b0000;
    wdata_out = wdata_in;
    load_data = 32'h0;
    fault     = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        byte_en   = 4'b0001 << addr;
        wdata_out = {4{wdata_in[7:0]}};
        load_data = (funct3 == F3_B) ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
      end
      F3_H, F3_HU: begin
        byte_en   = 4'b0011 << {addr[1], 1'b0};
        wdata_out = {2{wdata_in[15:0]}};
        load_data = (funct3 == F3_H) ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
        fault     = addr[0];
      end
      F3_W: begin
        byte_en   = 4'b1111;
        load_data = rdata;
        fault     = (addr != 2'b00);
      end
      default: begin
        fault = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: drives the data memory req/ack handshake, stalls the pipeline
// while an access is outstanding and holds the MEM/WB pipeline register.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RegWriteM,
  input  logic                     MemWriteM,
  input  logic [1:0]               ResultSrcM,
  input  logic [2:0]               Funct3M,
  input  logic [ADDRESS_WIDTH-1:0] RdM,
  input  logic [DATA_WIDTH-1:0]    ALUResultM,
  input  logic [DATA_WIDTH-1:0]    WriteDataM,
  input  logic [DATA_WIDTH-1:0]    PCPlus4M,
  output logic                     DMemReq,
  output logic                     DMemWe,
  output logic [DATA_WIDTH-1:0]    DMemAddr,
  output logic [3:0]               DMemByteEn,
  output logic [DATA_WIDTH-1:0]    DMemWData,
  input  logic [DATA_WIDTH-1:0]    DMemRData,
  input  logic                     DMemAck,
  output logic                     StallM,
  output logic                     RegWriteW,
  output logic [1:0]               ResultSrcW,
  output logic [ADDRESS_WIDTH-1:0] RdW,
  output logic [DATA_WIDTH-1:0]    ALUResultW,
  output logic [DATA_WIDTH-1:0]    ReadDataW,
  output logic [DATA_WIDTH-1:0]    PCPlus4W,
  output logic                     LsuFaultW,
  output logic                     LsuStateM
);

  // Handshake: DMemReq is held high with address/data stable until the cycle
  // DMemAck is seen high; that cycle completes the access. Ack without req is ignored.

  lsu_state_t state, state_next;

  logic        is_store;
  logic        is_load;
  logic        access;
  logic        align_fault;
  logic        fault;
  logic [3:0]  byte_en;
  logic [31:0] load_data;

  lsu_align u_align (
    .funct3    (Funct3M),
    .addr      (ALUResultM[1:0]),
    .wdata_in  (WriteDataM),
    .rdata     (DMemRData),
    .byte_en   (byte_en),
    .wdata_out (DMemWData),
    .load_data (load_data),
    .fault     (align_fault)
  );

  // A store wins when both the store strobe and the load marker are set.
  assign is_store = MemWriteM;
  assign is_load  = (ResultSrcM == RS_MEM) && !MemWriteM;
  assign access   = is_store | is_load;
  assign fault    = access & align_fault;

  // Reset gates the request combinationally so a pending access is abandoned at once.
  assign DMemReq    = ~RST & ((state == WAIT) | (access & ~fault));
  assign DMemWe     = is_store;
  assign DMemAddr   = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
  assign DMemByteEn = is_store ? byte_en : 4'b0000;
  assign StallM     = DMemReq & ~DMemAck;
  assign LsuStateM  = (state == WAIT);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (DMemReq && !DMemAck) state_next = WAIT;
      WAIT:    if (DMemAck)             state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST || StallM) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      LsuFaultW  <= 1'b0;
    end else begin
      RegWriteW  <= RegWriteM & ~fault;
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= (is_load && !fault) ? load_data : '0;
      PCPlus4W   <= PCPlus4M;
      LsuFaultW  <= fault;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: one task per scenario with inline checks.
module tb_mem_stage_lsu;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic        DMemReq, DMemWe;
  logic [31:0] DMemAddr;
  logic [3:0]  DMemByteEn;
  logic [31:0] DMemWData, DMemRData;
  logic        DMemAck;
  logic        StallM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic        LsuFaultW;
  logic        LsuStateM;

  int tests_run = 0;
  int tests_failed = 0;

  mem_stage_lsu #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .Funct3M    (Funct3M),
    .RdM        (RdM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M),
    .DMemReq    (DMemReq),
    .DMemWe     (DMemWe),
    .DMemAddr   (DMemAddr),
    .DMemByteEn (DMemByteEn),
    .DMemWData  (DMemWData),
    .DMemRData  (DMemRData),
    .DMemAck    (DMemAck),
    .StallM     (StallM),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .RdW        (RdW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W),
    .LsuFaultW  (LsuFaultW),
    .LsuStateM  (LsuStateM)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_nop;
    RegWriteM  = 1'b0;
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    Funct3M    = 3'b000;
    RdM        = 5'd0;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
    PCPlus4M   = 32'h0;
    DMemAck    = 1'b0;
    DMemRData  = 32'h0;
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
    RegWriteM  = 1'b1;
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b01;
    Funct3M    = f3;
    RdM        = rd;
    ALUResultM = addr;
    WriteDataM = 32'h0;
    PCPlus4M   = 32'h0000_0044;
  endtask

  task automatic drive_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    RegWriteM  = 1'b0;
    MemWriteM  = 1'b1;
    ResultSrcM = 2'b00;
    Funct3M    = f3;
    RdM        = 5'd0;
    ALUResultM = addr;
    WriteDataM = wd;
    PCPlus4M   = 32'h0000_0048;
  endtask

  task automatic test_reset;
    set_nop();
    RST = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({RegWriteW, RdW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, LsuFaultW} !== '0) begin
      tests_failed++;
      $display("FAIL reset_w_regs: got rw=%0b rd=%0d rs=%0b alu=%h rdata=%h pc4=%h flt=%0b, need all 0",
               RegWriteW, RdW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, LsuFaultW);
    end
    tests_run++;
    if ({DMemReq, StallM, LsuStateM} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got req=%0b stall=%0b wait=%0b, need 0 0 0", DMemReq, StallM, LsuStateM);
    end
    RST = 1'b0;
  endtask

  task automatic test_lw_zero_wait;
    drive_load(3'b010, 32'h0000_0100, 5'd5);
    DMemAck   = 1'b1;
    DMemRData = 32'hDEAD_BEEF;
    #1;
    tests_run++;
    if (DMemReq !== 1'b1 || DMemAddr !== 32'h100 || StallM !== 1'b0 || DMemWe !== 1'b0 || DMemByteEn !== 4'b0000) begin
      tests_failed++;
      $display("FAIL lw_req: got req=%0b addr=%h stall=%0b we=%0b be=%b, need 1 00000100 0 0 0000",
               DMemReq, DMemAddr, StallM, DMemWe, DMemByteEn);
    end
    tick();
    set_nop();
    tests_run++;
    if (ReadDataW !== 32'hDEAD_BEEF || RdW !== 5'd5 || RegWriteW !== 1'b1 || ResultSrcW !== 2'b01 ||
        LsuFaultW !== 1'b0 || PCPlus4W !== 32'h44 || LsuStateM !== 1'b0) begin
      tests_failed++;
      $display("FAIL lw_wb: got data=%h rd=%0d rw=%0b rs=%0b flt=%0b pc4=%h wait=%0b, need deadbeef 5 1 01 0 44 0",
               ReadDataW, RdW, RegWriteW, ResultSrcW, LsuFaultW, PCPlus4W, LsuStateM);
    end
  endtask

  task automatic test_load_extend;
    logic [2:0]  f3_v   [3] = '{3'b000, 3'b100, 3'b001};
    logic [31:0] addr_v [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] exp_v  [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};
    for (int i = 0; i < 3; i++) begin
      drive_load(f3_v[i], addr_v[i], 5'd10);
      DMemAck   = 1'b1;
      DMemRData = 32'h80FF_7F01;
      tick();
      set_nop();
      tests_run++;
      if (ReadDataW !== exp_v[i] || RegWriteW !== 1'b1) begin
        tests_failed++;
        $display("FAIL load_ext[%0d]: got data=%h rw=%0b, need %h 1", i, ReadDataW, RegWriteW, exp_v[i]);
      end
    end
  endtask

  task automatic test_store_wait;
    int stalls = 0;
    drive_store(3'b001, 32'h0000_0102, 32'h1234_ABCD);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (StallM === 1'b1) stalls++;
      tests_run++;
      if (DMemReq !== 1'b1 || DMemWe !== 1'b1 || DMemByteEn !== 4'b1100 ||
          DMemWData !== 32'hABCD_ABCD || DMemAddr !== 32'h100) begin
        tests_failed++;
        $display("FAIL sh_hold[%0d]: got req=%0b we=%0b be=%b wd=%h addr=%h, need 1 1 1100 abcdabcd 00000100",
                 i, DMemReq, DMemWe, DMemByteEn, DMemWData, DMemAddr);
      end
      tick();
      tests_run++;
      if (RegWriteW !== 1'b0 || RdW !== 5'd0 || LsuFaultW !== 1'b0 || LsuStateM !== 1'b1) begin
        tests_failed++;
        $display("FAIL sh_bubble[%0d]: got rw=%0b rd=%0d flt=%0b wait=%0b, need 0 0 0 1",
                 i, RegWriteW, RdW, LsuFaultW, LsuStateM);
      end
    end
    DMemAck = 1'b1;
    #1;
    if (StallM === 1'b1) stalls++;
    tests_run++;
    if (stalls !== 3 || DMemReq !== 1'b1) begin
      tests_failed++;
      $display("FAIL sh_stall_count: got stalls=%0d req=%0b, need 3 1", stalls, DMemReq);
    end
    tick();
    set_nop();
    tests_run++;
    if (RegWriteW !== 1'b0 || LsuFaultW !== 1'b0 || PCPlus4W !== 32'h48 || LsuStateM !== 1'b0) begin
      tests_failed++;
      $display("FAIL sh_wb: got rw=%0b flt=%0b pc4=%h wait=%0b, need 0 0 48 0", RegWriteW, LsuFaultW, PCPlus4W, LsuStateM);
    end
    drive_store(3'b000, 32'h0000_0101, 32'h0000_00A5);
    DMemAck = 1'b1;
    #1;
    tests_run++;
    if (DMemByteEn !== 4'b0010 || DMemWData !== 32'hA5A5_A5A5 || StallM !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_lanes: got be=%b wd=%h stall=%0b, need 0010 a5a5a5a5 0", DMemByteEn, DMemWData, StallM);
    end
    tick();
    set_nop();
  endtask

  task automatic test_fault;
    drive_load(3'b010, 32'h0000_0101, 5'd7);
    #1;
    tests_run++;
    if (DMemReq !== 1'b0 || StallM !== 1'b0) begin
      tests_failed++;
      $display("FAIL lw_misalign_req: got req=%0b stall=%0b, need 0 0", DMemReq, StallM);
    end
    tick();
    tests_run++;
    if (LsuFaultW !== 1'b1 || RegWriteW !== 1'b0) begin
      tests_failed++;
      $display("FAIL lw_misalign_wb: got flt=%0b rw=%0b, need 1 0", LsuFaultW, RegWriteW);
    end
    drive_load(3'b011, 32'h0000_0100, 5'd7);
    #1;
    tests_run++;
    if (DMemReq !== 1'b0 || StallM !== 1'b0) begin
      tests_failed++;
      $display("FAIL f3_illegal_req: got req=%0b stall=%0b, need 0 0", DMemReq, StallM);
    end
    tick();
    tests_run++;
    if (LsuFaultW !== 1'b1 || RegWriteW !== 1'b0) begin
      tests_failed++;
      $display("FAIL f3_illegal_wb: got flt=%0b rw=%0b, need 1 0", LsuFaultW, RegWriteW);
    end
    set_nop();
    tick();
    tests_run++;
    if (LsuFaultW !== 1'b0) begin
      tests_failed++;
      $display("FAIL fault_pulse: got flt=%0b, need 0", LsuFaultW);
    end
  endtask

  task automatic test_passthrough;
    RegWriteM  = 1'b1;
    ResultSrcM = 2'b00;
    Funct3M    = 3'b011;
    RdM        = 5'd3;
    ALUResultM = 32'h0000_0055;
    PCPlus4M   = 32'h0000_0080;
    DMemAck    = 1'b1;
    #1;
    tests_run++;
    if (DMemReq !== 1'b0 || StallM !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_req: got req=%0b stall=%0b, need 0 0", DMemReq, StallM);
    end
    tick();
    set_nop();
    tests_run++;
    if (ALUResultW !== 32'h55 || RegWriteW !== 1'b1 || RdW !== 5'd3 || LsuFaultW !== 1'b0 ||
        ReadDataW !== 32'h0 || PCPlus4W !== 32'h80 || LsuStateM !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_wb: got alu=%h rw=%0b rd=%0d flt=%0b data=%h pc4=%h wait=%0b, need 55 1 3 0 0 80 0",
               ALUResultW, RegWriteW, RdW, LsuFaultW, ReadDataW, PCPlus4W, LsuStateM);
    end
  endtask

  task automatic test_reset_in_wait;
    drive_load(3'b010, 32'h0000_0100, 5'd6);
    DMemAck = 1'b0;
    tick();
    tick();
    tests_run++;
    if (LsuStateM !== 1'b1 || DMemReq !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_wait_pre: got wait=%0b req=%0b, need 1 1", LsuStateM, DMemReq);
    end
    RST = 1'b1;
    #1;
    tests_run++;
    if (DMemReq !== 1'b0 || StallM !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_wait_gate: got req=%0b stall=%0b, need 0 0", DMemReq, StallM);
    end
    tick();
    set_nop();
    RST = 1'b0;
    tick();
    DMemAck   = 1'b1;
    DMemRData = 32'h1111_2222;
    #1;
    tests_run++;
    if (DMemReq !== 1'b0 || StallM !== 1'b0 || LsuStateM !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_ack_ctrl: got req=%0b stall=%0b wait=%0b, need 0 0 0", DMemReq, StallM, LsuStateM);
    end
    tick();
    DMemAck = 1'b0;
    tests_run++;
    if ({RegWriteW, RdW, ALUResultW, ReadDataW, LsuFaultW} !== '0 || LsuStateM !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_ack_wb: got rw=%0b rd=%0d alu=%h data=%h flt=%0b wait=%0b, need all 0",
               RegWriteW, RdW, ALUResultW, ReadDataW, LsuFaultW, LsuStateM);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] mem_word = 32'h0;
    logic [3:0]  stall_seq = 4'b0000;
    drive_store(3'b010, 32'h0000_0200, 32'hCAFE_F00D);
    #1;
    stall_seq[3] = StallM;
    tick();
    DMemAck = 1'b1;
    #1;
    if (DMemReq && DMemWe && DMemAddr == 32'h200 && DMemByteEn == 4'b1111) mem_word = DMemWData;
    stall_seq[2] = StallM;
    tick();
    drive_load(3'b010, 32'h0000_0200, 5'd9);
    DMemAck = 1'b0;
    #1;
    tests_run++;
    if (LsuStateM !== 1'b0 || DMemReq !== 1'b1 || DMemWe !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second_req: got wait=%0b req=%0b we=%0b, need 0 1 0", LsuStateM, DMemReq, DMemWe);
    end
    stall_seq[1] = StallM;
    tick();
    DMemAck   = 1'b1;
    DMemRData = mem_word;
    #1;
    stall_seq[0] = StallM;
    tick();
    set_nop();
    tests_run++;
    if (stall_seq !== 4'b1010) begin
      tests_failed++;
      $display("FAIL b2b_stall_seq: got %b, need 1010", stall_seq);
    end
    tests_run++;
    if (ReadDataW !== 32'hCAFE_F00D || RdW !== 5'd9 || RegWriteW !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_load_data: got data=%h rd=%0d rw=%0b, need cafef00d 9 1", ReadDataW, RdW, RegWriteW);
    end
  endtask

  initial begin
    test_reset();
    test_lw_zero_wait();
    test_load_extend();
    test_store_wait();
    test_fault();
    test_passthrough();
    test_reset_in_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-stage load/store unit. It is the consumer of the execute-to-memory pipeline register and drives the data memory through a req/ack handshake that tolerates wait states. It performs byte/halfword alignment, sign/zero extension and fault detection. It holds the memory-to-writeback pipeline register and raises a stall while an access is outstanding.

Parameters:
DATA_WIDTH, 32, datapath width; only 32 is supported (four byte lanes)
ADDRESS_WIDTH, 5, register-file address width

Ports:
CLK  input  1  clock, all state updates on posedge
RST  input  1  synchronous active-high reset
RegWriteM  input  1  register write enable from EX/MEM
MemWriteM  input  1  store strobe
ResultSrcM  input  2  00 ALU, 01 load, 10 PC+4; 01 marks a load
Funct3M  input  3  load/store size: 000 b, 001 h, 010 w, 100 bu, 101 hu
RdM  input  ADDRESS_WIDTH  destination register
ALUResultM  input  DATA_WIDTH  effective byte address, or ALU result
WriteDataM  input  DATA_WIDTH  store data (rs2)
PCPlus4M  input  DATA_WIDTH  PC+4
DMemReq  output  1  memory request
DMemWe  output  1  1 store, 0 load
DMemAddr  output  DATA_WIDTH  word address: ALUResultM with [1:0] forced to 00
DMemByteEn  output  4  store lane enables; 0000 for loads
DMemWData  output  DATA_WIDTH  lane-replicated store data
DMemRData  input  DATA_WIDTH  read word
DMemAck  input  1  completes the current request; may be combinational (zero-wait)
StallM  output  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
RegWriteW  output  1  registered
ResultSrcW  output  2  registered
RdW  output  ADDRESS_WIDTH  registered
ALUResultW  output  DATA_WIDTH  registered
ReadDataW  output  DATA_WIDTH  registered, extended load data
PCPlus4W  output  DATA_WIDTH  registered
LsuFaultW  output  1  registered one-cycle pulse on misaligned access or illegal Funct3M

Behaviour:
- Access means a load (ResultSrcM==01) or a store (MemWriteM=1). Both at once is treated as a store.
- Fault conditions:
  - Funct3M is 011, 110 or 111.
  - Word access with addr[1:0]!=00.
  - Halfword access (h/hu) with addr[0]!=0.
  - Faulting access: DMemReq is never raised, there is no stall, and the W register gets RegWriteW=0 and LsuFaultW=1.
- FSM has two states, IDLE and WAIT; reset state is IDLE.
- IDLE:
  - With a legal access, DMemReq=1 combinationally.
  - If DMemAck=1 in the same cycle, the access completes and the FSM stays in IDLE with StallM=0.
  - Otherwise StallM=1 and the FSM moves to WAIT.
- WAIT:
  - DMemReq=1 and StallM=1.
  - DMemAddr, DMemWe, DMemByteEn and DMemWData are held stable; the EX/MEM inputs stay stable because the upstream register is frozen.
  - On DMemAck=1: StallM=0, the access completes and the FSM returns to IDLE.
- StallM = DMemReq & ~DMemAck.
- DMemAck is ignored whenever DMemReq=0.
- W register:
  - Updates every cycle.
  - When StallM=1 it loads a bubble: RegWriteW=0, RdW=0, LsuFaultW=0, other fields don't-care.
  - Otherwise it captures the M fields, with ReadDataW set to the extracted load data (0 for non-loads).
  - Latency: load data is available in ReadDataW one clock after the ack cycle.
- Store lanes, with a = addr[1:0]:
  - sb: ByteEn = 0001<<a; WData = {4{WriteDataM[7:0]}}.
  - sh: ByteEn = 0011<<(2*a[1]); WData = {2{WriteDataM[15:0]}}.
  - sw: ByteEn = 1111; WData = WriteDataM.
- Load extraction:
  - Byte = DMemRData[8a+7:8a]; halfword = DMemRData[16a[1]+15:16a[1]].
  - lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word through.
- Non-access instructions pass through in one cycle with no request.
- Reset:
  - All W outputs are 0, DMemReq=0, StallM=0, FSM in IDLE.
  - RST asserted in WAIT drops DMemReq in that same cycle (combinational gating by RST). A subsequent late ack is ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - typedef lsu_state_t {IDLE, WAIT};
  - Funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - ResultSrc constants RS_ALU, RS_MEM, RS_PC4.
- One natural sub-module, lsu_align: purely combinational. It takes Funct3, addr[1:0], WriteDataM and DMemRData, and produces ByteEn, WData, load data and the fault flag.
- The FSM and W register stay in mem_stage_lsu.

Test Plan:
- lw at ALUResultM=0x100, RdM=5, RegWriteM=1, ack same cycle, DMemRData=0xDEADBEEF -> DMemAddr=0x100, StallM never 1; next cycle ReadDataW=0xDEADBEEF, RdW=5, RegWriteW=1.
- lb at 0x103 and lbu at 0x103, both with DMemRData=0x80FF7F01 -> ReadDataW=0xFFFFFF80 for lb and 0x00000080 for lbu; lh at 0x102 -> 0xFFFF80FF.
- sh at 0x102, WriteDataM=0x1234ABCD, ack after 3 cycles -> DMemByteEn=1100, DMemWData=0xABCDABCD, DMemAddr=0x100, all held stable; StallM=1 for exactly 3 cycles; W receives 3 bubbles then the store (RegWriteW=0).
- lw at 0x101 -> DMemReq stays 0, StallM=0, next cycle LsuFaultW=1 and RegWriteW=0; Funct3M=011 load -> same response.
- Load issued with no ack, RST asserted in the 2nd WAIT cycle, ack arrives one cycle after reset deasserts -> DMemReq=0 from the reset cycle onward, FSM in IDLE, all W outputs 0, the late ack has no effect.
- Back-to-back sw 0x200 then lw 0x200, each acked after 1 wait cycle -> two separate requests; StallM pattern 1,0,1,0; the lw returns the memory model's stored value.
